// File: rtl/sfp_row_ctrl.sv
// sfp_row_ctrl: row sequencer for the softmax-normalisation datapath.
// Per row it reads one psum vector, then pulses acc, then div, then writes
// the normalised vector to the output SRAM. The psum read port is shared
// with the core and arbitrated through psum_req/psum_gnt.
// Optional feature macro: SFP_ROW_CTRL_PERF_EN adds the stall_cnt output.
module sfp_row_ctrl #(
    parameter int addr_bw = 4,
    parameter int cnt_bw  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [cnt_bw-1:0]  rows_m1,
    input  logic [addr_bw-1:0] rd_base,
    input  logic [addr_bw-1:0] wr_base,
    input  logic               psum_gnt,
    output logic               psum_req,
    output logic               psum_ren,
    output logic [addr_bw-1:0] psum_addr,
    output logic [1:0]         inst,
    output logic               out_wen,
    output logic [addr_bw-1:0] out_addr,
    output logic               busy,
    output logic               done
`ifdef SFP_ROW_CTRL_PERF_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        ACC,
        DIV,
        WR,
        FIN
    } state_t;

    state_t state, state_nxt;

    logic [cnt_bw-1:0]  row;
    logic [cnt_bw-1:0]  rows_m1_q;
    logic [addr_bw-1:0] rd_base_q;
    logic [addr_bw-1:0] wr_base_q;
    logic               last_row;

    assign last_row = (row == rows_m1_q);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Job parameters are captured on launch; row advances after each write.
    always_ff @(posedge clk) begin
        if (reset) begin
            row       <= '0;
            rows_m1_q <= '0;
            rd_base_q <= '0;
            wr_base_q <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                row       <= '0;
                rows_m1_q <= rows_m1;
                rd_base_q <= rd_base;
                wr_base_q <= wr_base;
            end
        end else if (state == WR && !last_row) begin
            row <= row + 1'b1;
        end
    end

    // Next-state logic; RD stalls until the read port is granted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RD;
            RD:   if (psum_gnt) state_nxt = ACC;
            ACC:  state_nxt = DIV;
            DIV:  state_nxt = WR;
            WR:   state_nxt = last_row ? FIN : RD;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode of the registered state; only psum_ren also follows the grant.
    always_comb begin
        psum_req  = 1'b0;
        psum_ren  = 1'b0;
        psum_addr = '0;
        inst      = 2'b00;
        out_wen   = 1'b0;
        out_addr  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            RD: begin
                psum_req  = 1'b1;
                psum_ren  = psum_gnt;
                psum_addr = rd_base_q + addr_bw'(row);
                busy      = 1'b1;
            end
            ACC: begin
                inst = 2'b10;
                busy = 1'b1;
            end
            DIV: begin
                inst = 2'b01;
                busy = 1'b1;
            end
            WR: begin
                out_wen  = 1'b1;
                out_addr = wr_base_q + addr_bw'(row);
                busy     = 1'b1;
            end
            FIN: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef SFP_ROW_CTRL_PERF_EN
    // Count ungranted read-request cycles per job, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == RD && !psum_gnt && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
